// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, reset vector default, fetch FSM
// state encoding and small PC helpers.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_FLUSH = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential successor; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry fetch output register: loaded from the memory response, drained
// by decode, cleared by a redirect.
module fetch_buf
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    input  logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Payload only moves on a load, so it stays put while decode stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            instr <= '0;
        end else if (load && !clear) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a one-entry
// output buffer toward decode, and redirect handling with response flushing.
module fetch_ctrl
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            if_ready
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            buf_free;
    logic            req_fire;
    logic            load_buf;

    // Nothing loads the buffer while in REQ, so once the request is raised
    // buf_free stays true and the request holds until accepted.
    assign buf_free      = !if_valid || if_ready;
    assign imem_req_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        load_buf       = 1'b0;
        case (state)
            FETCH_IDLE: begin
                state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                imem_req_valid = buf_free;
                req_fire       = buf_free && imem_req_ready;
                if (req_fire) begin
                    state_next = redirect_valid ? FETCH_FLUSH : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    load_buf   = !redirect_valid;
                    state_next = FETCH_REQ;
                end else if (redirect_valid) begin
                    state_next = FETCH_FLUSH;
                end
            end
            FETCH_FLUSH: begin
                // The stale response is the only thing in flight; drop it.
                if (imem_rsp_valid) begin
                    state_next = FETCH_REQ;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
        end else if (load_buf) begin
            fetch_pc <= seq_pc(req_pc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc <= '0;
        end else if (req_fire && !redirect_valid) begin
            req_pc <= fetch_pc;
        end
    end

    fetch_buf u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .load       (load_buf),
        .load_pc    (req_pc),
        .load_instr (imem_rsp_data),
        .ready      (if_ready),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

endmodule
